// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 5-9 data bits, optional odd/even parity and 1 or 2 stop bits.
// It synchronises the line, takes a 3-sample majority vote per bit and rejects false starts.
module uart_rx_cfg #(
  parameter int I_CLK_FREQ = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  // o_data_valid is a one-cycle strobe with no ready: o_data and both flags are qualified by it
  // and hold until the next frame completes, so the consumer must take them within one frame time.
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);

  // BIT_CNT must be at least 8 so the three vote samples fit inside one bit period.
  localparam int BIT_CNT = I_CLK_FREQ / BAUDRATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PAR       = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   samp0;
  logic                   samp1;
  logic                   par_err;
  logic                   frm_err;
  logic                   maj;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rx_s    <= rx_meta;
    end
  end

  // The third vote is the live synchronised value at the decision cycle.
  assign maj = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      samp0        <= 1'b1;
      samp1        <= 1'b1;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      if (state != S_IDLE && state != S_WAIT_HIGH) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == CNT_S0) samp0 <= rx_s;
        if (cnt == CNT_S1) samp1 <= rx_s;
      end
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            // This cycle is cnt 0 of the start bit.
            state   <= S_START;
            cnt     <= CW'(1);
            bit_idx <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == CNT_DEC && maj) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == CNT_DEC) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (cnt == CNT_LAST) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (cnt == CNT_DEC) par_err <= ((^{shreg, maj}) != PAR_ODD);
          if (cnt == CNT_LAST) state <= S_STOP;
        end
        S_STOP: begin
          if (cnt == CNT_DEC) begin
            if (bit_idx == LAST_STOP) begin
              // Finish mid-stop-bit so a back-to-back start edge is not missed.
              o_data       <= shreg;
              o_data_valid <= 1'b1;
              o_parity_err <= par_err;
              o_frame_err  <= frm_err | ~maj;
              cnt          <= '0;
              bit_idx      <= '0;
              state        <= (frm_err | ~maj) ? S_WAIT_HIGH : S_IDLE;
            end else begin
              frm_err <= frm_err | ~maj;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy      = (state != S_IDLE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance at 16 clocks per bit, fed from a vector
// table, hand-written corner sequences and random frames checked against a line-level model.
module tb_uart_rx_cfg;

  localparam int BIT_CNT = 16;
  localparam int HALF    = 8;
  localparam int LAT_8N1 = 2 + 9 * BIT_CNT + HALF + 2;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       rxd8 = 1'b1;
  logic       rxd7 = 1'b1;
  logic [7:0] data8;
  logic       valid8, perr8, ferr8, busy8;
  logic [2:0] st8;
  logic [6:0] data7;
  logic       valid7, perr7, ferr7, busy7;
  logic [2:0] st7;

  logic [10:0] exp_q8[$];
  logic [10:0] exp_q7[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_strobe8 = 0;
  int last_v8 = 0;
  int cyc = 0;

  typedef struct {
    int         dut;
    logic [8:0] data;
    bit         flip;
    logic [1:0] stop;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  uart_rx_cfg #(.I_CLK_FREQ(16), .BAUDRATE(1)) dut8 (
    .i_clk(clk), .i_rst(i_rst), .i_rxd(rxd8), .o_data(data8), .o_data_valid(valid8),
    .o_parity_err(perr8), .o_frame_err(ferr8), .o_busy(busy8), .o_dbg_state(st8)
  );

  uart_rx_cfg #(.I_CLK_FREQ(16), .BAUDRATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
    .i_clk(clk), .i_rst(i_rst), .i_rxd(rxd7), .o_data(data7), .o_data_valid(valid7),
    .o_parity_err(perr7), .o_frame_err(ferr7), .o_busy(busy7), .o_dbg_state(st7)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic int cfg_db(input int w);  return (w == 8) ? 8 : 7; endfunction
  function automatic int cfg_par(input int w); return (w == 8) ? 0 : 2; endfunction
  function automatic int cfg_sb(input int w);  return (w == 8) ? 1 : 2; endfunction
  function automatic int cfg_n(input int w);
    return 1 + cfg_db(w) + ((cfg_par(w) != 0) ? 1 : 0) + cfg_sb(w);
  endfunction

  // Line bits of a frame, bit 0 first on the wire; flip inverts the correct parity bit.
  function automatic logic [15:0] build_frame(input int w, input logic [8:0] d, input bit flip,
                                              input logic [1:0] stop);
    logic [15:0] f;
    logic [8:0]  m;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < cfg_db(w); i++) begin f[k] = d[i]; k++; end
    if (cfg_par(w) != 0) begin
      m = (9'd1 << cfg_db(w)) - 9'd1;
      f[k] = (^(d & m)) ^ (cfg_par(w) == 1) ^ flip;
      k++;
    end
    for (int i = 0; i < cfg_sb(w); i++) begin f[k] = stop[i]; k++; end
    return f;
  endfunction

  // Reference model: reads the frame back from the line bits; result is {perr, ferr, data}.
  function automatic logic [10:0] model(input int w, input logic [15:0] f);
    logic [8:0] d;
    int ones;
    int pos;
    bit perr;
    bit ferr;
    d = '0;
    ones = 0;
    for (int i = 0; i < cfg_db(w); i++) begin
      d[i] = f[1 + i];
      ones += int'(f[1 + i]);
    end
    pos = 1 + cfg_db(w);
    perr = 1'b0;
    if (cfg_par(w) != 0) begin
      ones += int'(f[pos]);
      pos++;
      perr = (cfg_par(w) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    end
    ferr = 1'b0;
    for (int i = 0; i < cfg_sb(w); i++) if (f[pos + i] == 1'b0) ferr = 1'b1;
    return {perr, ferr, d};
  endfunction

  // driver tasks
  task automatic set_line(input int w, input logic v);
    if (w == 8) rxd8 = v;
    else rxd7 = v;
  endtask

  // gb/go: bit and in-bit cycle of a one-cycle glitch; rb: bit whose cycle 4 gets a reset pulse.
  task automatic send_frame(input int w, input logic [15:0] f, input int gb, input int go,
                            input int rb);
    for (int k = 0; k < cfg_n(w); k++) begin
      for (int j = 0; j < BIT_CNT; j++) begin
        if (k == rb && j == 4) begin
          i_rst = 1'b1;
          set_line(w, 1'b1);
          @(posedge clk); #1;
          i_rst = 1'b0;
          return;
        end
        set_line(w, (k == gb && j == go) ? ~f[k] : f[k]);
        @(posedge clk); #1;
      end
    end
    set_line(w, 1'b1);
  endtask

  task automatic push_exp(input int w, input logic [10:0] e);
    if (w == 8) exp_q8.push_back(e);
    else exp_q7.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while ((exp_q8.size() != 0 || exp_q7.size() != 0) && b < budget) begin
      @(posedge clk); #1;
      b++;
    end
    check("drain_pending", exp_q8.size() + exp_q7.size(), 0);
    exp_q8.delete();
    exp_q7.delete();
  endtask

  // scoreboard
  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (valid8) begin
        n_strobe8++;
        last_v8 = cyc;
        if (exp_q8.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL strobe8: unexpected strobe data=%0h, required no strobe", data8);
        end else begin
          e = exp_q8.pop_front();
          check("rx8", {21'b0, perr8, ferr8, 1'b0, data8}, {21'b0, e});
        end
      end
      if (valid7) begin
        if (exp_q7.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL strobe7: unexpected strobe data=%0h, required no strobe", data7);
        end else begin
          e = exp_q7.pop_front();
          check("rx7", {21'b0, perr7, ferr7, 2'b0, data7}, {21'b0, e});
        end
      end
    end
  endtask

  initial begin
    vec_t vt[8];
    logic [15:0] f;
    logic [8:0]  d;
    logic [1:0]  sp;
    bit          fl;
    int          w;
    int          t0;
    int          s0;
    int          gap;

    vt[0] = '{8, 9'h075, 1'b0, 2'b11, 9'h075, 1'b0, 1'b0};
    vt[1] = '{7, 9'h041, 1'b0, 2'b11, 9'h041, 1'b0, 1'b0};
    vt[2] = '{7, 9'h041, 1'b1, 2'b11, 9'h041, 1'b1, 1'b0};
    vt[3] = '{7, 9'h02a, 1'b0, 2'b11, 9'h02a, 1'b0, 1'b0};
    vt[4] = '{7, 9'h07f, 1'b0, 2'b10, 9'h07f, 1'b0, 1'b1};
    vt[5] = '{8, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    vt[6] = '{8, 9'h0ff, 1'b0, 2'b11, 9'h0ff, 1'b0, 1'b0};
    vt[7] = '{8, 9'h081, 1'b0, 2'b00, 9'h081, 1'b0, 1'b1};

    fork monitor(); join_none

    repeat (5) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("reset8", {data8, valid8, perr8, ferr8, busy8}, 0);
    check("reset7", {data7, valid7, perr7, ferr7, busy7}, 0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      f = build_frame(vt[i].dut, vt[i].data, vt[i].flip, vt[i].stop);
      push_exp(vt[i].dut, {vt[i].exp_perr, vt[i].exp_ferr, vt[i].exp_data});
      t0 = cyc;
      send_frame(vt[i].dut, f, -1, 0, -1);
      wait_drain(40);
      if (i == 0) begin
        check("lat_8n1", last_v8 - t0, LAT_8N1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_8n1", {data8, valid8}, {8'h75, 1'b0});
      end
      repeat (4) @(posedge clk);
      #1;
    end

    // false start
    s0 = n_strobe8;
    rxd8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd8 = 1'b1;
    check("fs_busy_hi", busy8, 1);
    repeat (8) @(posedge clk);
    #1;
    check("fs_busy_lo", busy8, 0);
    repeat (30) @(posedge clk);
    #1;
    check("fs_nostrobe", n_strobe8 - s0, 0);

    // framing error followed by a held break
    s0 = n_strobe8;
    f = build_frame(8, 9'h033, 1'b0, 2'b00);
    push_exp(8, {2'b01, 9'h033});
    send_frame(8, f, -1, 0, -1);
    rxd8 = 1'b0;
    repeat (3 * BIT_CNT) @(posedge clk);
    #1;
    check("brk_pending", exp_q8.size(), 0);
    check("brk_strobes", n_strobe8 - s0, 1);
    check("brk_busy", busy8, 1);
    rxd8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("brk_idle", busy8, 0);
    f = build_frame(8, 9'h05a, 1'b0, 2'b11);
    push_exp(8, {2'b00, 9'h05a});
    send_frame(8, f, -1, 0, -1);
    wait_drain(40);

    // glitch at cnt HALF of data bit 3 (line bit 4)
    f = build_frame(8, 9'h0ff, 1'b0, 2'b11);
    push_exp(8, {2'b00, 9'h0ff});
    send_frame(8, f, 4, HALF, -1);
    wait_drain(40);

    // reset pulse during data bit 4 (line bit 5)
    s0 = n_strobe8;
    f = build_frame(8, 9'h0c3, 1'b0, 2'b11);
    send_frame(8, f, -1, 0, 5);
    check("rst_outputs", {data8, valid8, perr8, ferr8, busy8}, 0);
    repeat (40) @(posedge clk);
    #1;
    check("rst_nostrobe", n_strobe8 - s0, 0);
    f = build_frame(8, 9'h0a5, 1'b0, 2'b11);
    push_exp(8, {2'b00, 9'h0a5});
    send_frame(8, f, -1, 0, -1);
    wait_drain(40);

    // random frames against the model
    for (int r = 0; r < 40; r++) begin
      w  = ($urandom_range(0, 1) == 0) ? 8 : 7;
      d  = 9'($urandom_range(0, (1 << cfg_db(w)) - 1));
      fl = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      f  = build_frame(w, d, fl, sp);
      push_exp(w, model(w, f));
      send_frame(w, f, -1, 0, -1);
      gap = $urandom_range(0, 8);
      if (sp != 2'b11) gap += 4;
      repeat (gap) @(posedge clk);
      #1;
    end
    wait_drain(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
